// File: rtl/la_trig_seq.sv
// la_trig_seq: multi-stage trigger sequencer for the logic analyser.
//
// Sits between the input sampler and the capture controller. Up to STAGES
// conditions are evaluated strictly in order. Each condition combines a masked
// level match with an optional edge on one selectable channel. A stage is
// complete after match_cnt (minimum 1) matching cycles, which need not be
// consecutive. When the last stage completes, trig_out pulses for one cycle.
//
// Optional feature (macro LA_TRIG_DELAY_EN):
//   Adds the trig_delay port. Completion of the last stage then waits
//   trig_delay cycles in the DELAY state before trig_out fires.
//   trig_delay = 0 gives the same timing as the build without the macro.
//
// Ports:
//   clk         in   sample clock, rising edge
//   rst         in   synchronous reset, active-high
//   din         in   sampled channel data (DW bits)
//   arm         in   pulse: start or restart the sequence at stage 0
//   abort       in   pulse: return to idle
//   cfg_last    in   index of the final stage used
//   level_sel   in   per-stage required level, stage k at [k*DW +: DW]
//   level_mask  in   per-stage level mask, 1 = don't care
//   edge_sel    in   per-stage edge channel index, out of range selects ch0
//   edge_mode   in   per-stage edge mode: 00 none, 01 rise, 10 fall, 11 either
//   match_cnt   in   per-stage required match count, 0 treated as 1
//   trig_delay  in   (LA_TRIG_DELAY_EN only) post-completion delay in cycles
//   armed       out  high while waiting for the trigger conditions
//   stage       out  current stage index
//   trig_out    out  one-cycle trigger pulse
//   triggered   out  high from the trig_out cycle until re-arm/abort/reset
module la_trig_seq #(
    parameter int DW     = 8,
    parameter int SELW   = 3,
    parameter int STAGES = 4,
    parameter int SIDX_W = 2,
    parameter int CW     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DW-1:0]          din,
    input  logic                   arm,
    input  logic                   abort,
    input  logic [SIDX_W-1:0]      cfg_last,
    input  logic [DW*STAGES-1:0]   level_sel,
    input  logic [DW*STAGES-1:0]   level_mask,
    input  logic [SELW*STAGES-1:0] edge_sel,
    input  logic [2*STAGES-1:0]    edge_mode,
    input  logic [CW*STAGES-1:0]   match_cnt,
`ifdef LA_TRIG_DELAY_EN
    input  logic [CW-1:0]          trig_delay,
`endif
    output logic                   armed,
    output logic [SIDX_W-1:0]      stage,
    output logic                   trig_out,
    output logic                   triggered
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
`ifdef LA_TRIG_DELAY_EN
        DELAY = 2'd2,
`endif
        TRIG  = 2'd3
    } state_t;

    localparam logic [SIDX_W-1:0] LAST_IDX = SIDX_W'(STAGES - 1);

    state_t              state;
    logic [DW-1:0]       din_last;
    logic [CW-1:0]       cnt;

    logic [DW-1:0]       cur_level;
    logic [DW-1:0]       cur_mask;
    logic [SELW-1:0]     cur_esel;
    logic [1:0]          cur_mode;
    logic [CW-1:0]       cur_need_raw;
    logic [CW-1:0]       need;
    logic                d_bit;
    logic                p_bit;
    logic                level_ok;
    logic                edge_ok;
    logic                match_cur;
    logic [CW:0]         cnt_plus1;
    logic                stage_done;
    logic [CW-1:0]       cnt_sat;
    logic [SIDX_W-1:0]   eff_last;

    // Pick the configuration slice of the stage currently being evaluated.
    always_comb begin
        cur_level    = '0;
        cur_mask     = '0;
        cur_esel     = '0;
        cur_mode     = '0;
        cur_need_raw = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (stage == SIDX_W'(k)) begin
                cur_level    = level_sel[k*DW +: DW];
                cur_mask     = level_mask[k*DW +: DW];
                cur_esel     = edge_sel[k*SELW +: SELW];
                cur_mode     = edge_mode[k*2 +: 2];
                cur_need_raw = match_cnt[k*CW +: CW];
            end
        end
    end

    // Edge channel lookup; an index past the last channel falls back to ch0
    // because the defaults are never overridden in that case.
    always_comb begin
        d_bit = din[0];
        p_bit = din_last[0];
        for (int i = 0; i < DW; i++) begin
            if (int'(cur_esel) == i) begin
                d_bit = din[i];
                p_bit = din_last[i];
            end
        end
    end

    // Condition of the current stage and its completion test.
    always_comb begin
        level_ok = &(~(din ^ cur_level) | cur_mask);
        case (cur_mode)
            2'b01:   edge_ok = ~p_bit & d_bit;
            2'b10:   edge_ok = p_bit & ~d_bit;
            2'b11:   edge_ok = p_bit ^ d_bit;
            default: edge_ok = 1'b1;
        endcase
        match_cur  = level_ok & edge_ok;
        need       = (cur_need_raw == '0) ? CW'(1) : cur_need_raw;
        cnt_plus1  = {1'b0, cnt} + (CW+1)'(1);
        stage_done = match_cur & (cnt_plus1 >= {1'b0, need});
        cnt_sat    = (cnt == '1) ? cnt : cnt + CW'(1);
        eff_last   = (cfg_last > LAST_IDX) ? LAST_IDX : cfg_last;
    end

    // Sequencer. abort beats arm, and arm beats any match in the same cycle.
    // trig_out defaults low so it can only ever be a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            din_last  <= '0;
            cnt       <= '0;
            stage     <= '0;
            armed     <= 1'b0;
            trig_out  <= 1'b0;
            triggered <= 1'b0;
        end else begin
            din_last <= din;
            trig_out <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                cnt       <= '0;
                stage     <= '0;
                armed     <= 1'b0;
                triggered <= 1'b0;
            end else if (arm) begin
                state     <= RUN;
                cnt       <= '0;
                stage     <= '0;
                armed     <= 1'b1;
                triggered <= 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        if (stage_done) begin
                            if (stage < eff_last) begin
                                stage <= stage + SIDX_W'(1);
                                cnt   <= '0;
`ifdef LA_TRIG_DELAY_EN
                            end else if (trig_delay != '0) begin
                                state <= DELAY;
                                armed <= 1'b0;
                                cnt   <= '0;
`endif
                            end else begin
                                state     <= TRIG;
                                armed     <= 1'b0;
                                trig_out  <= 1'b1;
                                triggered <= 1'b1;
                            end
                        end else if (match_cur) begin
                            cnt <= cnt_sat;
                        end
                    end
`ifdef LA_TRIG_DELAY_EN
                    // The completion cycle already used up one cycle of the
                    // delay, so fire when the next count reaches trig_delay.
                    DELAY: begin
                        if (cnt_plus1 >= {1'b0, trig_delay}) begin
                            state     <= TRIG;
                            trig_out  <= 1'b1;
                            triggered <= 1'b1;
                        end else begin
                            cnt <= cnt_sat;
                        end
                    end
`endif
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_la_trig_seq.sv
// tb_la_trig_seq: directed self-checking bench for la_trig_seq.
// The DUT is built with SELW=4 so an out-of-range edge channel index (9)
// can actually be expressed on the 8-channel instance.
// Optional feature (macro LA_TRIG_DELAY_EN) adds the trigger delay tests.
module tb_la_trig_seq;

    localparam int DW     = 8;
    localparam int SELW   = 4;
    localparam int STAGES = 4;
    localparam int SIDX_W = 2;
    localparam int CW     = 16;

    logic                   clk;
    logic                   rst;
    logic [DW-1:0]          din;
    logic                   arm;
    logic                   abort;
    logic [SIDX_W-1:0]      cfg_last;
    logic [DW*STAGES-1:0]   level_sel;
    logic [DW*STAGES-1:0]   level_mask;
    logic [SELW*STAGES-1:0] edge_sel;
    logic [2*STAGES-1:0]    edge_mode;
    logic [CW*STAGES-1:0]   match_cnt;
`ifdef LA_TRIG_DELAY_EN
    logic [CW-1:0]          trig_delay;
`endif
    logic                   armed;
    logic [SIDX_W-1:0]      stage;
    logic                   trig_out;
    logic                   triggered;

    int errors = 0;
    int checks = 0;

    la_trig_seq #(
        .DW(DW), .SELW(SELW), .STAGES(STAGES), .SIDX_W(SIDX_W), .CW(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .arm(arm),
        .abort(abort),
        .cfg_last(cfg_last),
        .level_sel(level_sel),
        .level_mask(level_mask),
        .edge_sel(edge_sel),
        .edge_mode(edge_mode),
        .match_cnt(match_cnt),
`ifdef LA_TRIG_DELAY_EN
        .trig_delay(trig_delay),
`endif
        .armed(armed),
        .stage(stage),
        .trig_out(trig_out),
        .triggered(triggered)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample 1ns after the edge that took them.
    task automatic applyStimulus(input logic [DW-1:0] d, input logic a, input logic ab);
        din   = d;
        arm   = a;
        abort = ab;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic setStage(input int k, input logic [DW-1:0] lvl, input logic [DW-1:0] msk,
                            input logic [SELW-1:0] esel, input logic [1:0] emode,
                            input logic [CW-1:0] mc);
        level_sel[k*DW +: DW]   = lvl;
        level_mask[k*DW +: DW]  = msk;
        edge_sel[k*SELW +: SELW] = esel;
        edge_mode[k*2 +: 2]     = emode;
        match_cnt[k*CW +: CW]   = mc;
    endtask

    task automatic checkAll(input string tag, input int a, input int s, input int t, input int tr);
        checkOutput({tag, ".armed"}, int'(armed), a);
        checkOutput({tag, ".stage"}, int'(stage), s);
        checkOutput({tag, ".trig_out"}, int'(trig_out), t);
        checkOutput({tag, ".triggered"}, int'(triggered), tr);
    endtask

    initial begin
        int found;
        rst        = 1'b1;
        din        = '0;
        arm        = 1'b0;
        abort      = 1'b0;
        cfg_last   = '0;
        level_sel  = '0;
        level_mask = '1;
        edge_sel   = '0;
        edge_mode  = '0;
        match_cnt  = '0;
`ifdef LA_TRIG_DELAY_EN
        trig_delay = '0;
`endif
        applyStimulus(8'h00, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkAll("reset", 0, 0, 0, 0);
        rst = 1'b0;

        // Single stage, level only, count 0 treated as 1
        $display("[TB] single stage level trigger");
        cfg_last = 2'd0;
        setStage(0, 8'h0F, 8'hF0, 4'd0, 2'b00, 16'd0);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkAll("t1_arm", 1, 0, 0, 0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkAll("t1_nomatch", 1, 0, 0, 0);
        applyStimulus(8'h3F, 1'b0, 1'b0);
        checkAll("t1_trig", 0, 0, 1, 1);
        applyStimulus(8'h3F, 1'b0, 1'b0);
        checkAll("t1_hold", 0, 0, 0, 1);

        // Two stages: 3 rises on ch2, then a fall on ch5
        $display("[TB] two stage edge sequence");
        cfg_last = 2'd1;
        setStage(0, 8'h00, 8'hFF, 4'd2, 2'b01, 16'd3);
        setStage(1, 8'h00, 8'hFF, 4'd5, 2'b10, 16'd1);
        applyStimulus(8'h20, 1'b1, 1'b0);
        checkAll("t2_arm", 1, 0, 0, 0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkAll("t2_early_fall", 1, 0, 0, 0);
        applyStimulus(8'h20, 1'b0, 1'b0);
        applyStimulus(8'h24, 1'b0, 1'b0);
        applyStimulus(8'h20, 1'b0, 1'b0);
        applyStimulus(8'h24, 1'b0, 1'b0);
        checkAll("t2_rise2", 1, 0, 0, 0);
        applyStimulus(8'h20, 1'b0, 1'b0);
        applyStimulus(8'h24, 1'b0, 1'b0);
        checkAll("t2_rise3", 1, 1, 0, 0);
        applyStimulus(8'h24, 1'b0, 1'b0);
        checkAll("t2_wait", 1, 1, 0, 0);
        applyStimulus(8'h04, 1'b0, 1'b0);
        checkAll("t2_trig", 0, 1, 1, 1);
        applyStimulus(8'h04, 1'b0, 1'b0);
        checkAll("t2_hold", 0, 1, 0, 1);

        // Out-of-range edge channel index selects ch0
        $display("[TB] edge_sel out of range");
        cfg_last = 2'd0;
        setStage(0, 8'h00, 8'hFF, 4'd9, 2'b11, 16'd1);
        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'h02, 1'b0, 1'b0);
        checkAll("t3_ch1", 1, 0, 0, 0);
        applyStimulus(8'h03, 1'b0, 1'b0);
        checkAll("t3_ch0", 0, 0, 1, 1);

        // Abort wins over arm while part way through stage 1
        $display("[TB] abort with arm");
        cfg_last = 2'd1;
        setStage(0, 8'h00, 8'hFF, 4'd2, 2'b01, 16'd3);
        setStage(1, 8'h00, 8'hFF, 4'd5, 2'b10, 16'd2);
        applyStimulus(8'h20, 1'b1, 1'b0);
        applyStimulus(8'h24, 1'b0, 1'b0);
        applyStimulus(8'h20, 1'b0, 1'b0);
        applyStimulus(8'h24, 1'b0, 1'b0);
        applyStimulus(8'h20, 1'b0, 1'b0);
        applyStimulus(8'h24, 1'b0, 1'b0);
        applyStimulus(8'h04, 1'b0, 1'b0);
        checkAll("t4_stage1_cnt1", 1, 1, 0, 0);
        applyStimulus(8'h04, 1'b1, 1'b1);
        checkAll("t4_abort", 0, 0, 0, 0);
        applyStimulus(8'h24, 1'b0, 1'b0);
        checkAll("t4_idle", 0, 0, 0, 0);
        applyStimulus(8'h24, 1'b1, 1'b0);
        checkAll("t4_rearm", 1, 0, 0, 0);
        applyStimulus(8'h20, 1'b0, 1'b0);
        applyStimulus(8'h24, 1'b0, 1'b0);
        applyStimulus(8'h20, 1'b0, 1'b0);
        applyStimulus(8'h24, 1'b0, 1'b0);
        checkAll("t4_rise2", 1, 0, 0, 0);

        // Reset mid-RUN, then mid-TRIG
        $display("[TB] reset during run and trig");
        rst = 1'b1;
        applyStimulus(8'h20, 1'b0, 1'b0);
        checkAll("t5_rst_run", 0, 0, 0, 0);
        rst = 1'b0;
        cfg_last = 2'd0;
        setStage(0, 8'h0F, 8'hF0, 4'd0, 2'b00, 16'd0);
        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'h0F, 1'b0, 1'b0);
        checkAll("t5_trig", 0, 0, 1, 1);
        rst = 1'b1;
        applyStimulus(8'h0F, 1'b0, 1'b0);
        checkAll("t5_rst_trig", 0, 0, 0, 0);
        rst = 1'b0;
        setStage(0, 8'h00, 8'hFF, 4'd3, 2'b01, 16'd1);
        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'h08, 1'b0, 1'b0);
        checkAll("t5_rise_after_rst", 0, 0, 1, 1);

`ifdef LA_TRIG_DELAY_EN
        // Delay of 5 cycles versus delay 0
        $display("[TB] trigger delay");
        setStage(0, 8'h0F, 8'hF0, 4'd0, 2'b00, 16'd0);
        trig_delay = 16'd0;
        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'h3F, 1'b0, 1'b0);
        checkAll("t6_delay0", 0, 0, 1, 1);
        trig_delay = 16'd5;
        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'h3F, 1'b0, 1'b0);
        checkAll("t6_complete", 0, 0, 0, 0);
        found = -1;
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(8'h3F, 1'b0, 1'b0);
            if (trig_out && found < 0) found = i;
        end
        checkOutput("t6_delay5_cycle", found, 5);
        checkOutput("t6_delay5_triggered", int'(triggered), 1);
        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'h3F, 1'b0, 1'b0);
        applyStimulus(8'h3F, 1'b0, 1'b0);
        applyStimulus(8'h3F, 1'b0, 1'b1);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(8'h3F, 1'b0, 1'b0);
            if (trig_out) found++;
        end
        checkOutput("t6_abort_pulses", found, 0);
        checkAll("t6_abort", 0, 0, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
